get_sequence_step_timeout: RTL
==============================

Name: get_sequence_step_timeout

Overview:
- Downstream consumer of the VCSEL pulse-period stage; driven by the same sensor-init sequencer.
- Takes a sequence-step type and the already-computed VCSEL pulse period (PCLKs).
- Reads the 16-bit encoded timeout register over the shared I2C read FSM and read FIFO, then decodes it to macro-clocks (MCLKs).
- Converts MCLKs to microseconds, writes both results into the global variable RAM, and presents them on its outputs.

Parameters:
- DIVISOR, 1000, constant divisor used for both ns-to-us divisions (the divider's width is sized for this value).
- MEM_WRITE, 1'b1, mem_rw value meaning write.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in S_IDLE
- step_type  input  8  8'h00 pre-range, 8'h01 final-range; any other value is invalid
- vcsel_pulse_period  input  8  PCLKs from the upstream stage; held stable from start until done
- done  output  1  one-cycle pulse when the operation completes or aborts
- busy  output  1  high whenever the FSM is not in S_IDLE
- read_start  output  1  one-cycle pulse to the I2C read FSM
- read_done  input  1  read FSM complete
- fnc_sel  output  2  2'b01 (read) during the register phase
- n_bytes  output  4  4'd2 during the register phase
- reg_address_out  output  8  8'h51 for pre-range, 8'h71 for final-range
- fifo_data_in  input  8  read FIFO data
- fifo_read_en  output  1  one-cycle pop request
- fifo_read_valid  input  1  fifo_data_in is valid this cycle
- mem_addr  output  8  RAM byte address
- mem_data_out  output  8  RAM write data
- mem_start  output  1  one-cycle RAM request pulse
- mem_done  input  1  RAM transaction complete
- mem_rw  output  1  RAM direction (MEM_WRITE)
- timeout_mclks  output  16  decoded timeout in MCLKs
- timeout_us  output  32  timeout in microseconds
- error  output  1  sticky until the next start

Behaviour:
- Reset (asynchronous): state S_IDLE. done, busy, read_start, fifo_read_en, mem_start, error = 0. fnc_sel, n_bytes, reg_address_out, mem_addr, mem_data_out, mem_rw = 0. timeout_mclks and timeout_us = 0.
- Reset mid-operation aborts immediately; any pending read or RAM transaction is abandoned and no done pulse is issued.
- S_IDLE: on start, clear error and latch step_type and vcsel_pulse_period.
  - Invalid step_type: set error and go to S_DONE; no read and no RAM write occur.
  - Valid step_type: go to S_REQ.
- S_REQ: pulse read_start for 1 cycle with fnc_sel=01, n_bytes=2 and the selected address, then go to S_WAIT_RD.
- S_WAIT_RD: hold until read_done.
- S_POP_HI: pulse fifo_read_en, then go to S_WAIT_HI. S_WAIT_HI: on fifo_read_valid capture exponent E = fifo_data_in.
- S_POP_LO / S_WAIT_LO: same handshake, capturing mantissa M.
- No timeout on any wait state.
- S_DECODE: mclks = (M << E) + 1, evaluated at 24+ bits.
  - If E > 15 or the result exceeds 16'hFFFF: set error and saturate to 16'hFFFF, then continue.
- S_MACRO: numerator = vcsel × 3,813,120 + 500 (32-bit; the maximum 972,346,100 fits).
  - Restoring divide by DIVISOR, 1 quotient bit per cycle over 40 cycles, gives macro_ns (20-bit).
- S_US: numerator = mclks × macro_ns + (macro_ns >> 1), 40-bit.
  - Same divider, 40 cycles; the quotient's low 32 bits become timeout_us.
- After S_US, register timeout_mclks and timeout_us.
- S_MEM: write 6 bytes, big-endian, one transaction at a time.
  - Each byte: drive addr/data with mem_rw=MEM_WRITE, pulse mem_start for 1 cycle, wait for mem_done, then move to the next byte.
  - MCLKs go to base+0..1: pre-range base 8'h14, final-range base 8'h16.
  - us goes to base+0..3: pre-range base 8'h22, final-range base 8'h26.
- S_DONE: pulse done for 1 cycle, then return to S_IDLE. Outputs hold until the next successful start.
- start asserted while busy is ignored.
- Error or saturation still completes the RAM writes with the saturated values.

Test Plan:
- step_type=00, vcsel=14, FIFO bytes 0x01,0x03 -> reg_address_out=0x51; mclks=7, macro_ns=53384, us=400; RAM[0x14..15]=00 07, RAM[0x22..25]=00 00 01 90; error=0.
- step_type=01, vcsel=10, FIFO bytes 0x02,0x29 -> reg_address_out=0x71; mclks=165, us=6310; RAM[0x16..17]=00 A5, RAM[0x26..29]=00 00 18 A6.
- FIFO bytes 0x09,0xFF -> error=1, mclks=0xFFFF, done pulses once, all 6 RAM writes still occur.
- step_type=0x05 -> error=1, done within 3 cycles, read_start and mem_start never asserted.
- Delay read_done by 50 cycles and mem_done by 7 cycles per byte -> results unchanged, exactly 1 read_start, 2 fifo_read_en and 6 mem_start pulses.
- Assert reset during S_US, then start (type 00, vcsel 14, bytes 0x01,0x03) -> outputs zero immediately on reset, no done during reset, and the fresh run yields us=400.

Source files
------------

// File: rtl/get_sequence_step_timeout.sv
// get_sequence_step_timeout
//
// Reads the 16-bit encoded sequence-step timeout register (pre-range 0x51 or
// final-range 0x71) through the shared I2C read FSM and read FIFO. It decodes
// the register to macro-clocks, converts that count to microseconds using the
// VCSEL pulse period, writes both values big-endian into the global variable
// RAM, and presents them on its outputs.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   start, step_type           request (sampled in S_IDLE) and step selector
//   vcsel_pulse_period         PCLKs from the upstream stage
//   done, busy, error          completion pulse, activity flag, sticky error
//   read_start, read_done      I2C read FSM handshake
//   fnc_sel, n_bytes,
//   reg_address_out            read-command fields, driven during the read phase
//   fifo_read_en, fifo_read_valid,
//   fifo_data_in               read FIFO pop handshake
//   mem_addr, mem_data_out,
//   mem_start, mem_done, mem_rw RAM write port, one byte per transaction
//   timeout_mclks, timeout_us  results, held until overwritten by a later run
module get_sequence_step_timeout #(
  parameter int unsigned DIVISOR   = 1000,
  parameter logic        MEM_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  step_type,
  input  logic [7:0]  vcsel_pulse_period,
  output logic        done,
  output logic        busy,
  output logic        read_start,
  input  logic        read_done,
  output logic [1:0]  fnc_sel,
  output logic [3:0]  n_bytes,
  output logic [7:0]  reg_address_out,
  input  logic [7:0]  fifo_data_in,
  output logic        fifo_read_en,
  input  logic        fifo_read_valid,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_start,
  input  logic        mem_done,
  output logic        mem_rw,
  output logic [15:0] timeout_mclks,
  output logic [31:0] timeout_us,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_RD, S_POP_HI, S_WAIT_HI, S_POP_LO, S_WAIT_LO,
    S_DECODE, S_MACRO, S_US, S_MEM, S_MEM_WAIT, S_DONE
  } state_t;

  localparam logic [10:0] DIV_K       = 11'(DIVISOR);
  // One MCLK is 2304 PCLKs of 1655 ps; the later /1000 turns ps into ns.
  localparam logic [31:0] MACRO_SCALE = 32'd3813120;
  localparam logic [5:0]  DIV_STEPS   = 6'd40;

  state_t      state, next_state;
  logic        final_q;          // 1: final-range, 0: pre-range
  logic [7:0]  vcsel_q;
  logic [7:0]  exp_q;
  logic [7:0]  mant_q;
  logic [15:0] mclks_q;
  logic [39:0] div_num;          // dividend shifting out, quotient shifting in
  logic [9:0]  div_rem;
  logic [5:0]  div_cnt;
  logic [2:0]  byte_idx;

  logic        step_valid;
  logic [10:0] trial;
  logic        trial_ge;
  logic [10:0] trial_sub;
  logic [23:0] dec_sum;
  logic        dec_over;
  logic [31:0] macro_num;
  logic [39:0] us_num;
  logic [7:0]  mcl_base;
  logic [7:0]  us_base;

  assign step_valid = (step_type[7:1] == 7'd0);

  // Restoring divider step: the remainder stays below DIVISOR, so the
  // shifted trial value never needs more than 11 bits.
  assign trial     = {div_rem, div_num[39]};
  assign trial_ge  = (trial >= DIV_K);
  assign trial_sub = trial - DIV_K;

  // An exponent up to 15 keeps (M << E) + 1 within 24 bits.
  assign dec_sum  = ({16'd0, mant_q} << exp_q[3:0]) + 24'd1;
  assign dec_over = (exp_q > 8'd15) || (dec_sum > 24'h00FFFF);

  assign macro_num = 32'(vcsel_q) * MACRO_SCALE + 32'd500;
  // The divider holds macro_ns once the macro division has finished.
  assign us_num    = 40'(mclks_q) * 40'(div_num[19:0]) + 40'(div_num[19:1]);

  assign mcl_base = final_q ? 8'h16 : 8'h14;
  assign us_base  = final_q ? 8'h26 : 8'h22;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      final_q       <= 1'b0;
      vcsel_q       <= '0;
      exp_q         <= '0;
      mant_q        <= '0;
      mclks_q       <= '0;
      div_num       <= '0;
      div_rem       <= '0;
      div_cnt       <= '0;
      byte_idx      <= '0;
      timeout_mclks <= '0;
      timeout_us    <= '0;
      error         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          final_q <= step_type[0];
          vcsel_q <= vcsel_pulse_period;
          error   <= !step_valid;
        end
        S_WAIT_HI: if (fifo_read_valid) exp_q  <= fifo_data_in;
        S_WAIT_LO: if (fifo_read_valid) mant_q <= fifo_data_in;
        S_DECODE: begin
          if (dec_over) begin
            mclks_q <= 16'hFFFF;
            error   <= 1'b1;
          end else begin
            mclks_q <= dec_sum[15:0];
          end
          div_num <= {8'd0, macro_num};
          div_rem <= '0;
          div_cnt <= '0;
        end
        S_MACRO, S_US: begin
          if (div_cnt != DIV_STEPS) begin
            div_rem <= trial_ge ? trial_sub[9:0] : trial[9:0];
            div_num <= {div_num[38:0], trial_ge};
            div_cnt <= div_cnt + 6'd1;
          end else if (state == S_MACRO) begin
            div_num <= us_num;
            div_rem <= '0;
            div_cnt <= '0;
          end else begin
            timeout_mclks <= mclks_q;
            timeout_us    <= div_num[31:0];
            byte_idx      <= '0;
          end
        end
        S_MEM_WAIT: if (mem_done) byte_idx <= byte_idx + 3'd1;
        default: ;
      endcase
    end
  end

  // NOTE: every output and next_state gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    next_state      = state;
    done            = 1'b0;
    busy            = (state != S_IDLE);
    read_start      = 1'b0;
    fifo_read_en    = 1'b0;
    mem_start       = 1'b0;
    fnc_sel         = 2'b00;
    n_bytes         = 4'd0;
    reg_address_out = 8'h00;
    mem_addr        = 8'h00;
    mem_data_out    = 8'h00;
    mem_rw          = 1'b0;

    if (state inside {S_REQ, S_WAIT_RD, S_POP_HI, S_WAIT_HI, S_POP_LO, S_WAIT_LO}) begin
      fnc_sel         = 2'b01;
      n_bytes         = 4'd2;
      reg_address_out = final_q ? 8'h71 : 8'h51;
    end

    if (state inside {S_MEM, S_MEM_WAIT}) begin
      mem_rw = MEM_WRITE;
      case (byte_idx)
        3'd0:    begin mem_addr = mcl_base;         mem_data_out = timeout_mclks[15:8]; end
        3'd1:    begin mem_addr = mcl_base + 8'd1;  mem_data_out = timeout_mclks[7:0];  end
        3'd2:    begin mem_addr = us_base;          mem_data_out = timeout_us[31:24];   end
        3'd3:    begin mem_addr = us_base + 8'd1;   mem_data_out = timeout_us[23:16];   end
        3'd4:    begin mem_addr = us_base + 8'd2;   mem_data_out = timeout_us[15:8];    end
        default: begin mem_addr = us_base + 8'd3;   mem_data_out = timeout_us[7:0];     end
      endcase
    end

    case (state)
      S_IDLE:     if (start) next_state = step_valid ? S_REQ : S_DONE;
      S_REQ:      begin read_start = 1'b1; next_state = S_WAIT_RD; end
      S_WAIT_RD:  if (read_done) next_state = S_POP_HI;
      S_POP_HI:   begin fifo_read_en = 1'b1; next_state = S_WAIT_HI; end
      S_WAIT_HI:  if (fifo_read_valid) next_state = S_POP_LO;
      S_POP_LO:   begin fifo_read_en = 1'b1; next_state = S_WAIT_LO; end
      S_WAIT_LO:  if (fifo_read_valid) next_state = S_DECODE;
      S_DECODE:   next_state = S_MACRO;
      S_MACRO:    if (div_cnt == DIV_STEPS) next_state = S_US;
      S_US:       if (div_cnt == DIV_STEPS) next_state = S_MEM;
      S_MEM:      begin mem_start = 1'b1; next_state = S_MEM_WAIT; end
      S_MEM_WAIT: if (mem_done) next_state = (byte_idx == 3'd5) ? S_DONE : S_MEM;
      S_DONE:     begin done = 1'b1; next_state = S_IDLE; end
      default:    next_state = S_IDLE;
    endcase
  end

endmodule
